// File: rtl/light_timer_pkg.sv
// Shared types and constants for the light_timer duration timer.
package light_timer_pkg;

    localparam int unsigned DUR_W              = 4;
    localparam int unsigned DEF_TICKS_PER_UNIT = 50_000_000;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StDone
    } state_e;

endpackage

// File: rtl/light_timer_tick_gen.sv
// Prescaler: emits a one-cycle tick every TICKS_PER_UNIT enabled cycles; clr restarts the unit.
module tick_gen
    import light_timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_UNIT = DEF_TICKS_PER_UNIT,
    parameter int unsigned PRESC_W        = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [PRESC_W-1:0] Last = PRESC_W'(TICKS_PER_UNIT - 1);

    logic [PRESC_W-1:0] cnt_q, cnt_d;

    // A clear on the same edge discards the pending tick so a restart starts a full unit.
    assign tick = en && !clr && (cnt_q == Last);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == Last) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/light_timer.sv
// Duration timer answering the INICIO/FIN handshake; LIGHT_TIMER_PAUSE_EN adds a hold input.
module light_timer
    import light_timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_UNIT = DEF_TICKS_PER_UNIT,
    parameter int unsigned PRESC_W        = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             INICIO,
    input  logic [DUR_W-1:0] data,
    output logic             FIN,
    output logic             busy,
    output logic [DUR_W-1:0] remaining
`ifdef LIGHT_TIMER_PAUSE_EN
    ,
    input  logic             hold
`endif
);

    state_e           state_q, state_d;
    logic [DUR_W-1:0] rem_q, rem_d;
    logic             fin_q, fin_d;
    logic             hold_w;
    logic             tick;
    logic             tick_en;

`ifdef LIGHT_TIMER_PAUSE_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    assign tick_en = (state_q == StCount) && !hold_w;

    tick_gen #(
        .TICKS_PER_UNIT(TICKS_PER_UNIT),
        .PRESC_W       (PRESC_W)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (INICIO),
        .en  (tick_en),
        .tick(tick)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        // A start request outranks expiry, so a same-edge restart swallows the pending FIN.
        if (INICIO) begin
            if (data != '0) begin
                state_d = StCount;
                rem_d   = data;
            end else begin
                state_d = StDone;
                rem_d   = '0;
            end
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StCount: begin
                    if (tick) begin
                        rem_d = rem_q - DUR_W'(1);
                        if (rem_q == DUR_W'(1)) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
        fin_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            fin_q   <= fin_d;
        end
    end

    assign FIN       = fin_q;
    assign busy      = (state_q == StCount);
    assign remaining = rem_q;

endmodule

// File: tb/tb_light_timer.sv
// Self-checking bench for light_timer: vector table, directed corner sequences, random vs. model.
module tb_light_timer;

    localparam int unsigned T = 4;
`ifdef LIGHT_TIMER_PAUSE_EN
    localparam bit PauseEn = 1'b1;
`else
    localparam bit PauseEn = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       INICIO;
    logic [3:0] data;
    logic       hold_s;
    logic       FIN;
    logic       busy;
    logic [3:0] remaining;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: elapsed counting cycles against the total D*T.
    int m_mode = 0;  // 0 idle, 1 counting, 2 finished
    int m_d    = 0;
    int m_el   = 0;

    typedef struct packed {
        logic       r;
        logic       ini;
        logic [3:0] d;
        logic       fin;
        logic       busy;
        logic [3:0] rem;
    } vec_t;

    vec_t vecs[$];

    light_timer #(
        .TICKS_PER_UNIT(T),
        .PRESC_W       (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .INICIO   (INICIO),
        .data     (data),
        .FIN      (FIN),
        .busy     (busy),
        .remaining(remaining)
`ifdef LIGHT_TIMER_PAUSE_EN
        ,
        .hold     (hold_s)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic r, input logic ini, input logic [3:0] d,
                                input logic fin, input logic bz, input logic [3:0] rem);
        vecs.push_back('{r: r, ini: ini, d: d, fin: fin, busy: bz, rem: rem});
    endfunction

    function automatic logic [5:0] model_out();
        logic [3:0] rem;
        rem = (m_mode == 1) ? 4'(m_d - m_el / int'(T)) : 4'd0;
        return {m_mode == 2, m_mode == 1, rem};
    endfunction

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got fin/busy/rem=%b/%b/%0d, expected %b/%b/%0d",
                     name, act[5], act[4], act[3:0], exp[5], exp[4], exp[3:0]);
        end
    endtask

    // Apply inputs for one edge, then sample 1 time unit after it and advance the model.
    task automatic step(input logic r, input logic ini, input logic [3:0] d, input logic h);
        rst    = r;
        INICIO = ini;
        data   = d;
        hold_s = h;
        @(posedge clk);
        #1;
        if (r) begin
            m_mode = 0;
            m_d    = 0;
            m_el   = 0;
        end else if (ini) begin
            if (d != 4'd0) begin
                m_mode = 1;
                m_d    = int'(d);
                m_el   = 0;
            end else begin
                m_mode = 2;
            end
        end else if (m_mode == 1) begin
            if (!(PauseEn && h)) m_el++;
            if (m_el == m_d * int'(T)) m_mode = 2;
        end else if (m_mode == 2) begin
            m_mode = 0;
        end
    endtask

    task automatic run_hold(input bit do_hold, output int lat);
        lat = -1;
        step(1'b0, 1'b1, 4'd2, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            step(1'b0, 1'b0, 4'd0, do_hold && (k >= 2) && (k < 12));
            if (FIN === 1'b1 && lat < 0) lat = k;
        end
    endtask

    initial begin
        int nfin;
        int found;
        int lat0;
        int lat1;
        logic [5:0] diff;

        rst    = 1'b1;
        INICIO = 1'b0;
        data   = 4'd0;
        hold_s = 1'b0;

        // Basic count, D=3: units expire at +4/+8/+12
        add(1, 0, 0, 0, 0, 0);
        add(0, 1, 3, 0, 1, 3);
        repeat (3) add(0, 0, 0, 0, 1, 3);
        repeat (4) add(0, 0, 0, 0, 1, 2);
        repeat (4) add(0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        // Zero duration, then data ignored without INICIO
        add(0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 7, 0, 0, 0);
        // Collision: restart on the expiry edge
        add(0, 1, 1, 0, 1, 1);
        repeat (3) add(0, 0, 0, 0, 1, 1);
        add(0, 1, 1, 0, 1, 1);
        repeat (3) add(0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        // Restart with zero duration from COUNT
        add(0, 1, 2, 0, 1, 2);
        add(0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].ini, vecs[i].d, 1'b0);
            chk($sformatf("vec%0d", i), {FIN, busy, remaining},
                {vecs[i].fin, vecs[i].busy, vecs[i].rem});
        end

        // Restart: D=5 then D=2 six cycles later; one FIN 8 cycles after the second start
        nfin = 0;
        step(1'b0, 1'b1, 4'd5, 1'b0);
        if (FIN === 1'b1) nfin++;
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0);
            if (FIN === 1'b1) nfin++;
        end
        step(1'b0, 1'b1, 4'd2, 1'b0);
        if (FIN === 1'b1) nfin++;
        for (int k = 1; k <= 7; k++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0);
            if (FIN === 1'b1) nfin++;
        end
        chk("restart_no_early_fin", 6'(nfin), 6'd0);
        step(1'b0, 1'b0, 4'd0, 1'b0);
        chk("restart_fin", {FIN, busy, remaining}, 6'b10_0000);
        step(1'b0, 1'b0, 4'd0, 1'b0);
        chk("restart_fin_one_cycle", {FIN, busy, remaining}, 6'd0);

        // Reset mid-count at remaining=2
        step(1'b0, 1'b1, 4'd3, 1'b0);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0);
            if (remaining === 4'd2) found = 1;
        end
        chk("reset_reach_rem2", 6'(found), 6'd1);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("reset_outputs", {FIN, busy, remaining}, 6'd0);
        nfin = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0);
            if (FIN === 1'b1) nfin++;
        end
        chk("reset_no_fin", 6'(nfin), 6'd0);

`ifdef LIGHT_TIMER_PAUSE_EN
        run_hold(1'b0, lat0);
        run_hold(1'b1, lat1);
        chk("hold_unheld_latency", 6'(lat0), 6'd8);
        diff = 6'(lat1 - lat0);
        chk("hold_delay", diff, 6'd10);
`endif

        // Randomized traffic against the model
        step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("rand_reset", {FIN, busy, remaining}, model_out());
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       ini;
            logic [3:0] d;
            logic       h;
            r   = ($urandom_range(0, 199) == 0);
            ini = ($urandom_range(0, 23) == 0) || ($urandom_range(0, 299) == 0 && i[0]);
            d   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            h   = ($urandom_range(0, 3) == 0);
            step(r, ini, d, h);
            chk($sformatf("rand%0d", i), {FIN, busy, remaining}, model_out());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
